// File: rtl/wrr_burst_arb_tree.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wrr_burst_arb_tree: weighted round-robin arbiter with burst lock and stall hold |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wrr_burst_arb_tree #(
  parameter int unsigned NumIn       = 4,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned WeightWidth = 4,
  parameter int unsigned IdxWidth    = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic [NumIn*WeightWidth-1:0] weight_i,
  input  logic [NumIn-1:0]             req_i,
  input  logic [NumIn-1:0]             last_i,
  input  logic [NumIn*DataWidth-1:0]   data_i,
  output logic [NumIn-1:0]             gnt_o,
  output logic                         req_o,
  input  logic                         gnt_i,
  output logic [DataWidth-1:0]         data_o,
  output logic                         last_o,
  output logic [IdxWidth-1:0]          idx_o
);

  if (NumIn == 1) begin : g_pass
    assign req_o  = req_i[0];
    assign gnt_o  = gnt_i;
    assign data_o = data_i[DataWidth-1:0];
    assign last_o = last_i[0];
    assign idx_o  = '0;
  end else begin : g_arb
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumIn - 1);

    logic [IdxWidth-1:0]    rr_q, rr_d;
    logic [IdxWidth-1:0]    lock_idx_q, lock_idx_d;
    logic [IdxWidth-1:0]    hold_idx_q, hold_idx_d;
    logic [WeightWidth-1:0] credit_q, credit_d;
    logic                   lock_q, lock_d;
    logic                   hold_q, hold_d;

    logic [IdxWidth-1:0]    rr_pick;
    logic [IdxWidth-1:0]    sel;
    logic [WeightWidth-1:0] w_field;
    logic [WeightWidth-1:0] wt;
    logic [WeightWidth-1:0] cnt;
    logic                   any_req;
    logic                   hs;

    // Scan offsets from the top down so the smallest cyclic offset from rr_q wins.
    always_comb begin
      rr_pick = '0;
      for (int k = NumIn - 1; k >= 0; k--) begin
        if (req_i[(int'(rr_q) + k) % int'(NumIn)]) begin
          rr_pick = IdxWidth'((int'(rr_q) + k) % int'(NumIn));
        end
      end
    end

    always_comb begin
      any_req = |req_i;
      if (!any_req) begin
        sel = '0;
      end else if (lock_q) begin
        sel = lock_idx_q;
      end else if (hold_q) begin
        sel = hold_idx_q;
      end else begin
        sel = rr_pick;
      end
    end

    assign req_o  = req_i[sel];
    assign last_o = last_i[sel];
    assign data_o = data_i[sel*DataWidth +: DataWidth];
    assign idx_o  = sel;
    assign hs     = req_o && gnt_i;

    always_comb begin
      gnt_o = '0;
      if (gnt_i && any_req) begin
        gnt_o[sel] = 1'b1;
      end
    end

    always_comb begin
      w_field = weight_i[sel*WeightWidth +: WeightWidth];
      wt      = (w_field == '0) ? WeightWidth'(1) : w_field;
      if (sel == rr_q) begin
        cnt = (&credit_q) ? credit_q : credit_q + WeightWidth'(1);
      end else begin
        cnt = WeightWidth'(1);
      end
    end

    always_comb begin
      rr_d       = rr_q;
      credit_d   = credit_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      hold_d     = hold_q;
      hold_idx_d = hold_idx_q;
      if (flush_i) begin
        rr_d       = '0;
        credit_d   = '0;
        lock_d     = 1'b0;
        lock_idx_d = '0;
        hold_d     = 1'b0;
        hold_idx_d = '0;
      end else if (hs) begin
        hold_d = 1'b0;
        if (!last_o) begin
          lock_d     = 1'b1;
          lock_idx_d = sel;
        end else begin
          lock_d = 1'b0;
          // Quota reached: hand priority to the next index, else keep it here.
          if (cnt >= wt) begin
            rr_d     = (sel == LastIdx) ? '0 : sel + IdxWidth'(1);
            credit_d = '0;
          end else begin
            rr_d     = sel;
            credit_d = cnt;
          end
        end
      end else if (req_o && !lock_q) begin
        hold_d     = 1'b1;
        hold_idx_d = sel;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rr_q       <= '0;
        credit_q   <= '0;
        lock_q     <= 1'b0;
        lock_idx_q <= '0;
        hold_q     <= 1'b0;
        hold_idx_q <= '0;
      end else begin
        rr_q       <= rr_d;
        credit_q   <= credit_d;
        lock_q     <= lock_d;
        lock_idx_q <= lock_idx_d;
        hold_q     <= hold_d;
        hold_idx_q <= hold_idx_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wrr_burst_arb_tree.sv
`default_nettype none
// Bench for wrr_burst_arb_tree: directed scenarios plus random traffic against a queue-based reference model.
module tb_wrr_burst_arb_tree;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int WW = 4;
  localparam int IW = 2;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic            flush = 1'b0;
  logic            gnt   = 1'b0;
  logic [N*WW-1:0] weight = '0;
  logic [N-1:0]    req  = '0;
  logic [N-1:0]    last = '0;
  logic [N*DW-1:0] data = '0;
  logic [N-1:0]    gnt_o;
  logic            req_o;
  logic            last_o;
  logic [DW-1:0]   data_o;
  logic [IW-1:0]   idx_o;

  logic [N*WW-1:0] wcur = '0;

  wrr_burst_arb_tree #(.NumIn(N), .DataWidth(DW), .WeightWidth(WW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .weight_i(weight),
    .req_i(req), .last_i(last), .data_i(data), .gnt_o(gnt_o),
    .req_o(req_o), .gnt_i(gnt), .data_o(data_o), .last_o(last_o), .idx_o(idx_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            req;
    int            idx;
    logic [DW-1:0] data;
    bit            last;
    logic [N-1:0]  gnt;
    int            fixed;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state: who has priority, how many bursts it has used, and any lock/hold owner.
  int m_rr = 0, m_credit = 0, m_lock_idx = 0, m_hold_idx = 0;
  bit m_locked = 0, m_held = 0;

  task automatic model_clear();
    m_rr = 0; m_credit = 0; m_lock_idx = 0; m_hold_idx = 0;
    m_locked = 0; m_held = 0;
  endtask

  function automatic int model_sel();
    if (req == '0) return 0;
    if (m_locked) return m_lock_idx;
    if (m_held) return m_hold_idx;
    for (int k = 0; k < N; k++) if (req[(m_rr + k) % N]) return (m_rr + k) % N;
    return 0;
  endfunction

  task automatic model_step();
    int w, cnt, wt;
    bit r;
    if (!rst_n || flush) begin
      model_clear();
      return;
    end
    w = model_sel();
    r = (req != '0) && req[w];
    if (r && gnt) begin
      m_held = 0;
      if (!last[w]) begin
        m_locked = 1; m_lock_idx = w;
      end else begin
        m_locked = 0;
        cnt = (w == m_rr) ? ((m_credit + 1 > 15) ? 15 : m_credit + 1) : 1;
        wt  = int'(weight[w*WW +: WW]);
        if (wt == 0) wt = 1;
        if (cnt >= wt) begin
          m_rr = (w + 1) % N; m_credit = 0;
        end else begin
          m_rr = w; m_credit = cnt;
        end
      end
    end else if (r && !m_locked) begin
      m_held = 1; m_hold_idx = w;
    end
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l, input int fixed = -1,
                       input bit g = 1, input bit f = 0, input bit rs = 0, input bit fl = 0);
    exp_t e;
    int   s;
    @(posedge clk);
    model_step();
    #1;
    if (fl) begin
      if (m_locked) r[m_lock_idx] = 1'b1;
      if (m_held) r[m_hold_idx] = 1'b1;
    end
    req = r; last = l; gnt = g; flush = f; weight = wcur; rst_n = !rs;
    for (int i = 0; i < N; i++) data[i*DW +: DW] = $urandom;
    if (rs) model_clear();
    assert (rs || !((m_locked && !req[m_lock_idx]) || (m_held && !req[m_hold_idx])))
      else $error("upstream dropped a held or locked request");
    s       = model_sel();
    e.req   = (r != '0) && r[s];
    e.idx   = s;
    e.data  = data[s*DW +: DW];
    e.last  = l[s];
    e.gnt   = (g && r != '0) ? (N'(1) << s) : '0;
    e.fixed = fixed;
    sb.push_back(e);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("req_o", 32'(req_o), 32'(e.req));
        if (e.req) begin
          check("idx_o", 32'(idx_o), 32'(e.idx));
          check("data_o", data_o, e.data);
          check("last_o", 32'(last_o), 32'(e.last));
        end
        check("gnt_o", 32'(gnt_o), 32'(e.gnt));
        if (e.fixed >= 0) check("idx_seq", 32'(idx_o), 32'(e.fixed));
      end
    end
  end

  initial begin : driver
    int seq_a[6] = '{0, 1, 2, 3, 0, 1};
    int seq_b[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int seq_c[4] = '{0, 1, 0, 1};
    logic [N-1:0] r, l;

    wcur = 16'h1111;
    repeat (2) cycle('0, '0, 0, 1, 0, 1);
    cycle('0, '0, 0);
    foreach (seq_a[i]) cycle(4'b1111, 4'b1111, seq_a[i]);

    cycle('0, '0, -1, 1, 1);
    wcur = 16'h1113;
    foreach (seq_b[i]) cycle(4'b0011, 4'b0011, seq_b[i]);

    cycle('0, '0, -1, 1, 1);
    wcur = 16'h1110;
    foreach (seq_c[i]) cycle(4'b0011, 4'b0011, seq_c[i]);

    // Three-beat burst from input 1 while input 0 waits.
    cycle('0, '0, -1, 1, 1);
    wcur = 16'h1111;
    cycle(4'b0010, 4'b0000, 1);
    cycle(4'b0011, 4'b0001, 1);
    cycle(4'b0011, 4'b0011, 1);
    cycle(4'b0011, 4'b0011, 0);

    // Stall on input 0 while other requests appear.
    cycle('0, '0, -1, 1, 1);
    cycle(4'b0001, 4'b1111, 0, 0);
    repeat (3) cycle(4'b1111, 4'b1111, 0, 0);
    cycle(4'b1111, 4'b1111, 0, 1);
    cycle(4'b1111, 4'b1111, 1, 1);

    // Flush in the middle of an input-2 burst with credit 1.
    cycle('0, '0, -1, 1, 1);
    wcur = 16'h1311;
    cycle(4'b0100, 4'b0100, 2);
    cycle(4'b0100, 4'b0000, 2);
    cycle(4'b0101, 4'b0000, 2, 1, 1);
    cycle(4'b0111, 4'b0111, 0);

    // Reset in the middle of an input-1 burst.
    wcur = 16'h1111;
    cycle(4'b0010, 4'b0000, 1);
    cycle(4'b0011, 4'b0000, 0, 1, 0, 1);
    cycle('0, '0, 0, 1, 0, 1);
    cycle(4'b1111, 4'b1111, 0);
    cycle(4'b1111, 4'b1111, 1);
    cycle(4'b1111, 4'b1111, 2);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        for (int i = 0; i < N; i++) wcur[i*WW +: WW] = WW'($urandom_range(0, 5));
        if ($urandom_range(0, 3) == 0) wcur[WW-1:0] = 4'hf;
      end
      r = N'($urandom);
      l = N'($urandom | $urandom);
      cycle(r, l, -1, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0,
            $urandom_range(0, 299) == 0, 1);
    end

    @(posedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
